data_memory_ws: RTL and testbench
=================================

// Module: data_memory_ws
// PURPOSE
//  Byte-addressed, little-endian data memory for the pipeline MEM stage, with a
//  request/ready handshake and a configurable number of wait states.
//  Supports byte, half-word and word loads/stores, with sign or zero extension
//  on loads. Misaligned or illegal-size requests are flagged with a fault.
//  Sits between the MEM stage and the hazard unit; busy_o drives the stall.
// PARAMETERS
//  ADDR_BITS    10  byte-address bits used; depth = 2**ADDR_BITS bytes
//  WAIT_CYCLES  2   wait states between request accept and access (0..15)
// PORTS
//  clk_i    in   1   clock; all state changes on its rising edge
//  rst_i    in   1   synchronous, active-low reset
//  req_i    in   1   request strobe; sampled only in IDLE
//  we_i     in   1   1=store, 0=load
//  size_i   in   2   00=byte, 01=half, 10=word, 11=illegal
//  sign_i   in   1   load extension: 1=sign-extend, 0=zero-extend
//  addr_i   in   32  byte address; only [ADDR_BITS-1:0] used (upper bits alias)
//  wdata_i  in   32  store data, taken from the low bytes per size_i
//  ready_o  out  1   one-cycle completion pulse
//  fault_o  out  1   qualifies ready_o; 1=request rejected, no access made
//  rdata_o  out  32  load result; valid while ready_o=1, held afterwards
//  busy_o   out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_i=0 at an edge):
//   - state=IDLE; ready_o=0, fault_o=0, rdata_o=0, busy_o=0.
//   - Memory array is not cleared; its contents are undefined until written.
//   - Reset during WAIT cancels the request; a pending store is never written.
//  States: IDLE, WAIT, DONE.
//  IDLE, req_i=1 at edge E0: latch we/size/sign/addr/wdata, then:
//   - fault if size=11, half with addr[0]=1, or word with addr[1:0]!=0
//     -> DONE with fault_o=1. No memory write; rdata_o unchanged.
//   - else if WAIT_CYCLES=0: perform the access at E0 -> DONE.
//   - else: cnt<=WAIT_CYCLES -> WAIT.
//  WAIT: cnt decrements each edge; at the edge where cnt==1, perform the
//   access and go to DONE. Access edge = E0+WAIT_CYCLES.
//  DONE: ready_o=1 for exactly one cycle, then IDLE at the next edge.
//   - Latency: ready_o high in cycle E0+WAIT_CYCLES+1 (faults: cycle E0+1).
//   - Throughput: one request per WAIT_CYCLES+2 cycles.
//  req_i in WAIT or DONE is ignored (not queued); the requester re-presents it
//   once busy_o=0.
//  Store, little-endian:
//   - byte: mem[a]=wd[7:0]
//   - half: mem[a],mem[a+1]=wd[7:0],wd[15:8]
//   - word: mem[a..a+3]=wd[7:0]..wd[31:24]
//   - rdata_o is unchanged by stores.
//  Load: rdata_o<=bytes assembled little-endian. Byte and half results are
//   extended to 32 bits per sign_i. Loads read the memory state before any
//   store issued later.
//  ready_o=0 and fault_o=0 in IDLE and WAIT. fault_o=1 only together with
//   ready_o=1.
//  Aligned accesses never cross the top of the array, so there is no address
//   wrap. The highest word is addr[ADDR_BITS-1:0]=all ones minus 3.
// TESTING
//  1 Store word 0xDEADBEEF @0x10; load word @0x10 -> rdata_o=0xDEADBEEF, ready_o
//    in cycle E0+3 with WAIT_CYCLES=2; busy_o high for 3 cycles.
//  2 Then load byte @0x13: sign_i=1 -> 0xFFFFFFDE; sign_i=0 -> 0x000000DE.
//    Load half @0x10, sign_i=1 -> 0xFFFFBEEF.
//  3 Store half 0x1234 @0x11 -> ready_o=1, fault_o=1 in cycle E0+1.
//    Word @0x10 still reads 0xDEADBEEF. size_i=11 also faults.
//  4 req_i held high continuously -> accepted once every 4 cycles.
//    Extra strobes during WAIT or DONE are not executed.
//  5 Store word @0x20, rst_i=0 one cycle after accept -> all outputs 0;
//    a later load @0x20 does not return the cancelled store data.
//  6 Rebuild with WAIT_CYCLES=0; load word -> ready_o in cycle E0+1.
//    Address 0x400+0x10 aliases to 0x10 with ADDR_BITS=10.

Source files
------------

// File: rtl/data_memory_ws_if.sv
// rtl/data_memory_ws_if.sv - request/response bundle between MEM stage and data memory
interface data_memory_ws_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        fault_o;
  logic [31:0] rdata_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, size_i, sign_i, addr_i, wdata_i,
    input  ready_o, fault_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, we_i, size_i, sign_i, addr_i, wdata_i,
    output ready_o, fault_o, rdata_o, busy_o
  );
endinterface

// File: rtl/data_memory_ws.sv
// rtl/data_memory_ws.sv - byte-addressed little-endian data memory with wait states
module data_memory_ws #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  data_memory_ws_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  logic [7:0] mem [DEPTH];

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [1:0]             size_q;
  logic                   sign_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q;

  logic                   req_fault;
  logic                   acc_en;
  logic                   acc_we;
  logic [1:0]             acc_size;
  logic                   acc_sign;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [31:0]            acc_wdata;
  logic [ADDR_BITS-1:0]   a1, a2, a3;
  logic [31:0]            load_val;

  // Address bits above ADDR_BITS alias and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr_i[31:ADDR_BITS];

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  // Select the access source: with no wait states the access happens on the
  // accept edge straight from the request inputs, otherwise from the latched copy.
  always_comb begin
    req_fault = is_fault(bus.size_i, bus.addr_i[1:0]);
    acc_we    = we_q;
    acc_size  = size_q;
    acc_sign  = sign_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_en    = 1'b0;
    if (WAIT_CYCLES == 0) begin
      acc_we    = bus.we_i;
      acc_size  = bus.size_i;
      acc_sign  = bus.sign_i;
      acc_addr  = bus.addr_i[ADDR_BITS-1:0];
      acc_wdata = bus.wdata_i;
      acc_en    = rst_i && (state == ST_IDLE) && bus.req_i && !req_fault;
    end else begin
      acc_en    = rst_i && (state == ST_WAIT) && (cnt == 4'd1);
    end
  end

  // Assemble the little-endian load result and extend sub-word loads.
  always_comb begin
    a1 = acc_addr + ADDR_BITS'(1);
    a2 = acc_addr + ADDR_BITS'(2);
    a3 = acc_addr + ADDR_BITS'(3);
    case (acc_size)
      2'b00:   load_val = {{24{acc_sign & mem[acc_addr][7]}}, mem[acc_addr]};
      2'b01:   load_val = {{16{acc_sign & mem[a1][7]}}, mem[a1], mem[acc_addr]};
      default: load_val = {mem[a3], mem[a2], mem[a1], mem[acc_addr]};
    endcase
  end

  // Store path: memory is never reset, and a cancelled request never reaches here.
  always_ff @(posedge clk_i) begin
    if (acc_en && acc_we) begin
      mem[acc_addr] <= acc_wdata[7:0];
      if (acc_size != 2'b00) mem[a1] <= acc_wdata[15:8];
      if (acc_size == 2'b10) begin
        mem[a2] <= acc_wdata[23:16];
        mem[a3] <= acc_wdata[31:24];
      end
    end
  end

  // Request FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      bus.ready_o <= 1'b0;
      bus.fault_o <= 1'b0;
      bus.rdata_o <= 32'd0;
      bus.busy_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.ready_o <= 1'b0;
          bus.fault_o <= 1'b0;
          if (bus.req_i) begin
            we_q       <= bus.we_i;
            size_q     <= bus.size_i;
            sign_q     <= bus.sign_i;
            addr_q     <= bus.addr_i[ADDR_BITS-1:0];
            wdata_q    <= bus.wdata_i;
            bus.busy_o <= 1'b1;
            if (req_fault) begin
              state       <= ST_DONE;
              bus.ready_o <= 1'b1;
              bus.fault_o <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state       <= ST_DONE;
              bus.ready_o <= 1'b1;
              if (!acc_we) bus.rdata_o <= load_val;
            end else begin
              cnt   <= WAIT_INIT;
              state <= ST_WAIT;
            end
          end else begin
            bus.busy_o <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state       <= ST_DONE;
            bus.ready_o <= 1'b1;
            if (!acc_we) bus.rdata_o <= load_val;
          end
          cnt <= cnt - 4'd1;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          bus.ready_o <= 1'b0;
          bus.fault_o <= 1'b0;
          bus.busy_o  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          bus.ready_o <= 1'b0;
          bus.fault_o <= 1'b0;
          bus.busy_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ws.sv
// tb/tb_data_memory_ws.sv - self-checking bench for data_memory_ws
module tb_data_memory_ws;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_memory_ws_if bus2();
  data_memory_ws_if bus0();

  data_memory_ws #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus2.slave)
  );
  data_memory_ws #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  m2 [1024];
  logic [7:0]  m0 [1024];
  logic [31:0] last_rd2 = 32'd0;
  logic [31:0] last_rd0 = 32'd0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w0, input logic req, input logic we, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
    if (w0) begin
      bus0.req_i = req; bus0.we_i = we; bus0.size_i = size;
      bus0.sign_i = sign; bus0.addr_i = addr; bus0.wdata_i = wdata;
    end else begin
      bus2.req_i = req; bus2.we_i = we; bus2.size_i = size;
      bus2.sign_i = sign; bus2.addr_i = addr; bus2.wdata_i = wdata;
    end
  endtask

  function automatic logic model_fault(input logic [1:0] size, input logic [9:0] a);
    return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input bit w0, input logic [1:0] size,
                                             input logic sign, input logic [9:0] a);
    logic [31:0] val;
    int n;
    n = nbytes(size);
    val = 32'd0;
    for (int i = 0; i < n; i++)
      val = val | (32'(w0 ? m0[a + 10'(i)] : m2[a + 10'(i)]) << (8 * i));
    if (sign && n < 4 && val[8*n-1]) val = val | (32'hFFFFFFFF << (8 * n));
    return val;
  endfunction

  task automatic model_store(input bit w0, input logic [1:0] size, input logic [9:0] a,
                             input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) begin
      if (w0) m0[a + 10'(i)] = wdata[8*i +: 8];
      else    m2[a + 10'(i)] = wdata[8*i +: 8];
    end
  endtask

  task automatic do_req(input bit w0, input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic flt, output logic [31:0] rd,
                        output int nbusy, output logic post_ready, output logic post_busy);
    @(negedge clk);
    drive(w0, 1'b1, we, size, sign, addr, wdata);
    lat = -1; nbusy = 0; flt = 1'b0; rd = 32'd0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) drive(w0, 1'b0, we, size, sign, addr, wdata);
      if (w0 ? bus0.busy_o : bus2.busy_o) nbusy++;
      if (w0 ? bus0.ready_o : bus2.ready_o) begin
        lat = n;
        flt = w0 ? bus0.fault_o : bus2.fault_o;
        rd  = w0 ? bus0.rdata_o : bus2.rdata_o;
        break;
      end
    end
    @(negedge clk);
    post_ready = w0 ? bus0.ready_o : bus2.ready_o;
    post_busy  = w0 ? bus0.busy_o  : bus2.busy_o;
  endtask

  task automatic run_op(input bit w0, input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [9:0] a;
    logic ef, flt, pr, pb;
    logic [31:0] er, rd;
    int el, lat, nb;
    a  = addr[9:0];
    ef = model_fault(size, a);
    el = ef ? 1 : (w0 ? 1 : 3);
    er = w0 ? last_rd0 : last_rd2;
    if (!ef && !we) er = model_load(w0, size, sign, a);
    do_req(w0, we, size, sign, addr, wdata, lat, flt, rd, nb, pr, pb);
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " fault"}, 32'(flt), 32'(ef));
    chk({tag, " rdata"}, rd, er);
    chk({tag, " busy cycles"}, 32'(nb), 32'(el));
    chk({tag, " ready pulse width"}, 32'(pr), 32'd0);
    chk({tag, " busy after"}, 32'(pb), 32'd0);
    if (!ef && we) model_store(w0, size, a, wdata);
    if (!ef && !we) begin
      if (w0) last_rd0 = er; else last_rd2 = er;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, pulses, first_r, last_r;
    logic flt, pr, pb;
    logic [31:0] rd, a32;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 3, 32'h00000000};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        1'b0, 3, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        1'b0, 3, 32'hFFFFFFDE};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        1'b0, 3, 32'h000000DE};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 32'h010, 32'h0,        1'b0, 3, 32'hFFFFBEEF};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h011, 32'h00001234, 1'b1, 1, 32'hFFFFBEEF};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        1'b0, 3, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 2'd3, 1'b0, 32'h010, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h012, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        1'b0, 3, 32'h0000DEAD};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h010, 32'h0,        1'b0, 3, 32'hFFFFFFEF};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h3FC, 32'hA5A55A5A, 1'b0, 3, 32'hFFFFFFEF};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        1'b0, 3, 32'hA5A55A5A};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0,        1'b0, 3, 32'hFFFFFFA5};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h3FE, 32'h0,        1'b0, 3, 32'h0000A5A5};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h3FD, 32'h0,        1'b0, 3, 32'h0000005A};
    tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h410, 32'h0,        1'b0, 3, 32'hDEADBEEF};

    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(bus2.ready_o), 32'd0);
    chk("reset fault", 32'(bus2.fault_o), 32'd0);
    chk("reset rdata", bus2.rdata_o, 32'd0);
    chk("reset busy", 32'(bus2.busy_o), 32'd0);
    chk("reset busy w0", 32'(bus0.busy_o), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      do_req(1'b0, tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wdata,
             lat, flt, rd, nb, pr, pb);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d fault", i), 32'(flt), 32'(tbl[i].exp_fault));
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d busy cycles", i), 32'(nb), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d ready width", i), 32'(pr), 32'd0);
      if (tbl[i].we && !tbl[i].exp_fault)
        model_store(1'b0, tbl[i].size, tbl[i].addr[9:0], tbl[i].wdata);
      last_rd2 = tbl[i].exp_rd;
    end

    // Strobes arriving during WAIT/DONE must not re-execute the store.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h100);
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus2.ready_o) pulses++;
      if (k < 4) bus2.wdata_i = 32'h100 + 32'(k);
      else bus2.req_i = 1'b0;
    end
    chk("held store pulses", 32'(pulses), 32'd1);
    repeat (2) @(negedge clk);
    model_store(1'b0, 2'd2, 10'h30, 32'h100);
    run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "held store readback");

    // Continuous request: one accept every WAIT_CYCLES+2 cycles.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    pulses = 0; first_r = -1; last_r = -1;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      if (bus2.ready_o) begin
        pulses++;
        if (first_r < 0) first_r = s;
        last_r = s;
      end
      if (s == 16) bus2.req_i = 1'b0;
    end
    chk("stream pulses", 32'(pulses), 32'd4);
    chk("stream first ready", 32'(first_r), 32'd3);
    chk("stream last ready", 32'(last_r), 32'd15);
    repeat (3) @(negedge clk);

    // Reset during WAIT cancels a pending store.
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "pre-reset store");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    bus2.req_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("cancel ready", 32'(bus2.ready_o), 32'd0);
    chk("cancel fault", 32'(bus2.fault_o), 32'd0);
    chk("cancel rdata", bus2.rdata_o, 32'd0);
    chk("cancel busy", 32'(bus2.busy_o), 32'd0);
    rst = 1'b1;
    last_rd2 = 32'd0;
    last_rd0 = 32'd0;
    repeat (2) @(negedge clk);
    run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "post-cancel load");

    // Zero wait states and address aliasing.
    run_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0BADF00D, "w0 store");
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h410, 32'h0, "w0 alias load");
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h11, 32'h0, "w0 misaligned half");
    run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "w0 byte");

    // Randomized traffic over a pre-initialized window.
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 16; k++)
        run_op(w[0], 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), $urandom, "init");
      for (int i = 0; i < (w == 0 ? 150 : 80); i++) begin
        a32 = {$urandom, 10'h000};
        a32[9:0] = 10'h100 + 10'($urandom_range(0, 63));
        run_op(w[0], 1'($urandom), 2'($urandom), 1'($urandom), a32, $urandom,
               $sformatf("rand w%0d #%0d", w, i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
